// File: rtl/hex_rotate_ctrl_if.sv
// Select-generator bus: control inputs toward the rotator, display selects back out.
interface hex_rotate_ctrl_if;
    logic       run;
    logic       step;
    logic       dir;
    logic [1:0] sel3;
    logic [1:0] sel2;
    logic [1:0] sel1;
    logic [1:0] sel0;
    logic [1:0] pos;
    logic       tick;

    modport master (
        output run, step, dir,
        input  sel3, sel2, sel1, sel0, pos, tick
    );

    modport slave (
        input  run, step, dir,
        output sel3, sel2, sel1, sel0, pos, tick
    );
endinterface

// File: rtl/hex_rotate_ctrl.sv
// Rotating mux-select generator for four HEX displays: auto-scroll at a divided
// rate while run is high, one position per step edge while holding.
module hex_rotate_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic              clk,
    input  logic              reset,
    hex_rotate_ctrl_if.slave  bus
);

    typedef enum logic {HOLD, RUN} state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    state_t           state;
    logic [1:0]       pos_r;
    logic [CNT_W-1:0] div_cnt;
    logic             step_q;
    logic             tick_r;
    logic             step_rise;
    logic [1:0]       next_pos;

    assign step_rise = bus.step & ~step_q;
    assign next_pos  = bus.dir ? (pos_r - 2'd1) : (pos_r + 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HOLD;
            pos_r   <= '0;
            div_cnt <= '0;
            tick_r  <= 1'b0;
            // Capture step during reset so a held press is not seen as a new edge.
            step_q  <= bus.step;
        end else begin
            step_q <= bus.step;
            tick_r <= 1'b0;
            case (state)
                HOLD: begin
                    div_cnt <= '0;
                    if (step_rise) begin
                        pos_r  <= next_pos;
                        tick_r <= 1'b1;
                    end
                    if (bus.run) state <= RUN;
                end
                RUN: begin
                    if (div_cnt == TERM) begin
                        div_cnt <= '0;
                        pos_r   <= next_pos;
                        tick_r  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (!bus.run) begin
                        state   <= HOLD;
                        div_cnt <= '0;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign bus.pos  = pos_r;
    assign bus.tick = tick_r;
    assign bus.sel3 = pos_r;
    assign bus.sel2 = pos_r + 2'd1;
    assign bus.sel1 = pos_r + 2'd2;
    assign bus.sel0 = pos_r + 2'd3;

endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// Table-driven bench for hex_rotate_ctrl: a TICK_DIV=4 unit and a TICK_DIV=1 unit.
module tb_hex_rotate_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4;
    logic rst1;

    hex_rotate_ctrl_if bus4 ();
    hex_rotate_ctrl_if bus1 ();

    hex_rotate_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (bus4.slave)
    );

    hex_rotate_ctrl #(.TICK_DIV(1), .CNT_W(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1.slave)
    );

    typedef struct {
        bit         unit;
        bit         rst;
        bit         run;
        bit         step;
        bit         dir;
        logic [1:0] pos;
        bit         tick;
    } vec_t;

    vec_t vecs[$];
    vec_t expq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(bit u, bit r, bit rn, bit s, bit d, int p, bit t);
        vec_t v;
        v.unit = u;
        v.rst  = r;
        v.run  = rn;
        v.step = s;
        v.dir  = d;
        v.pos  = 2'(p);
        v.tick = t;
        vecs.push_back(v);
    endfunction

    task automatic check_vec(int idx);
        vec_t       e;
        logic [1:0] gp;
        logic       gt;
        logic [7:0] gs;
        logic [7:0] es;
        logic [1:0] p;
        e = expq.pop_front();
        if (e.unit) begin
            gp = bus1.pos;  gt = bus1.tick;
            gs = {bus1.sel3, bus1.sel2, bus1.sel1, bus1.sel0};
        end else begin
            gp = bus4.pos;  gt = bus4.tick;
            gs = {bus4.sel3, bus4.sel2, bus4.sel1, bus4.sel0};
        end
        p  = e.pos;
        es = {p, p + 2'd1, p + 2'd2, p + 2'd3};
        checks++;
        if (gp !== e.pos) begin
            errors++;
            $display("FAIL pos vec %0d unit %0d: got %0d want %0d", idx, e.unit, gp, e.pos);
        end
        checks++;
        if (gt !== e.tick) begin
            errors++;
            $display("FAIL tick vec %0d unit %0d: got %0b want %0b", idx, e.unit, gt, e.tick);
        end
        checks++;
        if (gs !== es) begin
            errors++;
            $display("FAIL sel vec %0d unit %0d: got %h want %h", idx, e.unit, gs, es);
        end
    endtask

    initial begin
        // TICK_DIV=4 unit: reset and idle
        add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0);
        repeat (10) add(0,0,0,0,0,0,0);
        // four manual pulses, dir=0, wrapping 3->0
        for (int k = 1; k <= 4; k++) begin
            add(0,0,0,1,0,k % 4,1);
            add(0,0,0,0,0,k % 4,0);
        end
        // step held for 5 cycles: a single advance
        add(0,0,0,1,0,1,1);
        repeat (4) add(0,0,0,1,0,1,0);
        add(0,0,0,0,0,1,0);
        // reset, then auto-scroll right; step pulses in RUN are ignored
        add(0,1,0,0,0,0,0);
        add(0,0,1,0,1,0,0);
        for (int c = 1; c <= 12; c++)
            add(0,0,1,(c % 4 == 2),1,(0 - c / 4) & 3,(c % 4 == 0));
        // two RUN cycles, three HOLD cycles, re-enter: full period again
        add(0,0,1,0,1,1,0); add(0,0,1,0,1,1,0);
        repeat (3) add(0,0,0,0,1,1,0);
        add(0,0,1,0,1,1,0);
        repeat (3) add(0,0,1,0,1,1,0);
        add(0,0,1,0,1,0,1);
        // run dropped on terminal count: advance happens, then nothing
        repeat (3) add(0,0,1,0,1,0,0);
        add(0,0,0,0,1,3,1);
        repeat (6) add(0,0,0,0,1,3,0);
        // reach pos=2 with div_cnt=3 and step high, then reset
        add(0,0,1,0,1,3,0);
        repeat (3) add(0,0,1,0,1,3,0);
        add(0,0,1,0,1,2,1);
        add(0,0,1,0,1,2,0); add(0,0,1,1,1,2,0); add(0,0,1,1,1,2,0);
        add(0,1,0,1,1,0,0);
        repeat (4) add(0,0,0,1,1,0,0);
        add(0,0,0,0,1,0,0);
        // TICK_DIV=1 unit: advance every RUN cycle, tick continuous
        add(1,1,0,0,0,0,0);
        add(1,0,1,0,0,0,0);
        for (int k = 1; k <= 5; k++) add(1,0,1,0,0,k % 4,1);
        add(1,0,0,0,0,2,1);
        add(1,0,0,0,0,2,0);

        rst4 = 1'b1; rst1 = 1'b1;
        bus4.run = 1'b0; bus4.step = 1'b0; bus4.dir = 1'b0;
        bus1.run = 1'b0; bus1.step = 1'b0; bus1.dir = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].unit) begin
                rst1 = vecs[i].rst; bus1.run = vecs[i].run;
                bus1.step = vecs[i].step; bus1.dir = vecs[i].dir;
                rst4 = 1'b0; bus4.run = 1'b0; bus4.step = 1'b0;
            end else begin
                rst4 = vecs[i].rst; bus4.run = vecs[i].run;
                bus4.step = vecs[i].step; bus4.dir = vecs[i].dir;
                rst1 = 1'b0; bus1.run = 1'b0; bus1.step = 1'b0;
            end
            expq.push_back(vecs[i]);
            @(posedge clk);
            #1;
            check_vec(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
